// File: rtl/e_mdu_pkg.sv
// Shared pipeline constants for the multiply/divide unit: E_MDOp encoding,
// default latencies and the MDU state type. CU decode and the hazard unit
// import the same package, so the encoding is defined in one place only.
package e_mdu_pkg;

  // E_MDOp encoding
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Default busy durations (cycles)
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the codes that launch a multi-cycle operation.
  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the divide codes (select the longer latency).
  function automatic logic is_md_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_md_calc.sv
// Combinational arithmetic core of the MDU: 64-bit products and
// quotient/remainder including the divide-by-zero and signed-overflow cases.
// On divide by zero the current HI/LO pass through, so the architectural
// registers are rewritten with their own values at completion.
module md_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_b_zero;
  logic               w_ovf;
  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic signed [31:0] w_q_s;
  logic signed [31:0] w_r_s;
  logic [31:0]        w_b_u;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;

  // Compute every candidate result, then select by operation code.
  always_comb begin
    w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    w_b_zero = (i_b == 32'd0);
    w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Divisors are forced to 1 in the special cases so the divider never
    // sees /0 or the overflowing -2^31 / -1; those results are replaced below.
    w_a_s = $signed(i_a);
    w_b_s = (w_b_zero || w_ovf) ? 32'sd1 : $signed(i_b);
    w_q_s = w_a_s / w_b_s;   // truncates toward zero
    w_r_s = w_a_s % w_b_s;   // takes the sign of the dividend

    w_b_u = w_b_zero ? 32'd1 : i_b;
    w_q_u = i_a / w_b_u;
    w_r_u = i_a % w_b_u;

    o_hi = i_hi;
    o_lo = i_lo;
    case (i_op)
      MD_MULT: begin
        o_hi = w_prod_s[63:32];
        o_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        o_hi = w_prod_u[63:32];
        o_lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        if (w_b_zero) begin
          o_hi = i_hi;
          o_lo = i_lo;
        end else if (w_ovf) begin
          o_hi = 32'd0;
          o_lo = 32'h8000_0000;
        end else begin
          o_hi = w_r_s;
          o_lo = w_q_s;
        end
      end
      MD_DIVU: begin
        if (!w_b_zero) begin
          o_hi = w_r_u;
          o_lo = w_q_u;
        end
      end
      default: begin
        o_hi = i_hi;
        o_lo = i_lo;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div with architectural
// HI/LO and mfhi/mflo/mthi/mtlo. The result is captured into temps at the
// start edge and committed to HI/LO on the edge where the counter reaches 0.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic        E_Start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_Busy,
  output logic [31:0] E_MDOut,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_tmp;
  logic [31:0] r_lo_tmp;

  logic        w_start;
  logic [31:0] w_calc_hi;
  logic [31:0] w_calc_lo;

  md_calc u_md_calc (
    .i_op (E_MDOp),
    .i_a  (E_A),
    .i_b  (E_B),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .o_hi (w_calc_hi),
    .o_lo (w_calc_lo)
  );

  // A start is only honoured from IDLE with a valid mult/div code.
  assign w_start = E_Start && is_md_start_op(E_MDOp) && (r_state == ST_IDLE);

  // State, latency counter, result temps and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_tmp <= 32'd0;
      r_lo_tmp <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cnt    <= is_md_div_op(E_MDOp) ? LP_DIV_CNT : LP_MULT_CNT;
            r_hi_tmp <= w_calc_hi;
            r_lo_tmp <= w_calc_lo;
            r_state  <= ST_BUSY;
          end else if (!E_Start) begin
            if (E_MDOp == MD_MTHI) r_hi <= E_A;
            if (E_MDOp == MD_MTLO) r_lo <= E_A;
          end
        end
        ST_BUSY: begin
          // Starts and moves to HI/LO are ignored while busy.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_hi_tmp;
            r_lo    <= r_lo_tmp;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign E_Busy = (r_state == ST_BUSY);
  assign E_HI   = r_hi;
  assign E_LO   = r_lo;

  // mfhi/mflo read path, zero latency from the registers.
  always_comb begin
    E_MDOut = 32'd0;
    if (E_MDOp == MD_MFHI) E_MDOut = r_hi;
    else if (E_MDOp == MD_MFLO) E_MDOut = r_lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: scoreboard of expected HI/LO/latency per
// operation, popped when the unit drops busy.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  E_MDOp = MD_NONE;
  logic        E_Start = 1'b0;
  logic [31:0] E_A = 32'd0;
  logic [31:0] E_B = 32'd0;
  logic        E_Busy;
  logic [31:0] E_MDOut;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  e_mdu dut (
    .clk     (clk),
    .reset   (reset),
    .E_MDOp  (E_MDOp),
    .E_Start (E_Start),
    .E_A     (E_A),
    .E_B     (E_B),
    .E_Busy  (E_Busy),
    .E_MDOut (E_MDOut),
    .E_HI    (E_HI),
    .E_LO    (E_LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] arch_hi = 32'd0;
  logic [31:0] arch_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference multiply via magnitudes and sign correction.
  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [31:0] ma, mb;
    logic [63:0] p;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    p  = {32'd0, ma} * {32'd0, mb};
    return (sgn && (a[31] ^ b[31])) ? -p : p;
  endfunction

  // Reference divide via magnitudes; returns {hi, lo}.
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                            input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return {cur_hi, cur_lo};
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // Push the expectation for an operation, then pulse E_Start across one edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] res;
    case (op)
      MD_MULT:  res = mul_model(a, b, 1'b1);
      MD_MULTU: res = mul_model(a, b, 1'b0);
      MD_DIV:   res = div_model(a, b, 1'b1, arch_hi, arch_lo);
      default:  res = div_model(a, b, 1'b0, arch_hi, arch_lo);
    endcase
    e.hi  = res[63:32];
    e.lo  = res[31:0];
    e.lat = (op == MD_DIV || op == MD_DIVU) ? DIV_CYCLES_DEF : MULT_CYCLES_DEF;
    sb_q.push_back(e);
    @(negedge clk);
    E_MDOp = op; E_A = a; E_B = b; E_Start = 1'b1;
    @(negedge clk);
    E_MDOp = MD_NONE; E_Start = 1'b0;
  endtask

  // Count busy cycles, optionally inject an op at busy cycle inj_cyc, then pop and compare.
  task automatic wait_done(input string tag, input int inj_cyc, input logic [3:0] inj_op);
    int bc;
    bit done;
    bit inj_clr;
    exp_t e;
    bc = 0; done = 1'b0; inj_clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inj_clr) begin
        E_MDOp = MD_NONE; E_Start = 1'b0; inj_clr = 1'b0;
      end
      if (!E_Busy) begin
        done = 1'b1;
        break;
      end
      bc++;
      if (bc == inj_cyc) begin
        E_MDOp  = inj_op;
        E_Start = is_md_start_op(inj_op);
        E_A     = 32'hDEAD_BEEF;
        E_B     = 32'd3;
        inj_clr = 1'b1;
        if (inj_op == MD_MFHI) begin
          #1 check({tag, "_mfhi_busy"}, {32'd0, E_MDOut}, {32'd0, arch_hi});
        end
      end
      @(negedge clk);
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_lat"}, 64'(bc), 64'(e.lat));
      check({tag, "_hi"}, {32'd0, E_HI}, {32'd0, e.hi});
      check({tag, "_lo"}, {32'd0, E_LO}, {32'd0, e.lo});
      arch_hi = e.hi;
      arch_lo = e.lo;
      $display("%s: busy=%0d HI=0x%08h LO=0x%08h", tag, bc, E_HI, E_LO);
    end
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v, input string tag);
    @(negedge clk);
    E_MDOp = op; E_A = v;
    @(negedge clk);
    E_MDOp = MD_NONE;
    if (op == MD_MTHI) arch_hi = v; else arch_lo = v;
    check({tag, "_hi"}, {32'd0, E_HI}, {32'd0, arch_hi});
    check({tag, "_lo"}, {32'd0, E_LO}, {32'd0, arch_lo});
    $display("%s: HI=0x%08h LO=0x%08h", tag, E_HI, E_LO);
  endtask

  task automatic read_mf(input string tag);
    E_MDOp = MD_MFHI;
    #1 check({tag, "_mfhi"}, {32'd0, E_MDOut}, {32'd0, arch_hi});
    E_MDOp = MD_MFLO;
    #1 check({tag, "_mflo"}, {32'd0, E_MDOut}, {32'd0, arch_lo});
    E_MDOp = MD_NONE;
    #1 check({tag, "_none"}, {32'd0, E_MDOut}, 64'd0);
    $display("%s: mfhi/mflo read", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, E_Busy}, 64'd0);
    check("rst_hi", {32'd0, E_HI}, 64'd0);
    check("rst_lo", {32'd0, E_LO}, 64'd0);
    check("rst_mdout", {32'd0, E_MDOut}, 64'd0);
    reset = 1'b1;
    $display("reset released");

    // Directed arithmetic
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);          wait_done("mult", -1, MD_NONE);
    check("mult_hi_const", {32'd0, E_HI}, 64'hFFFF_FFFF);
    check("mult_lo_const", {32'd0, E_LO}, 64'hFFFF_FFFA);
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);         wait_done("multu", -1, MD_NONE);
    check("multu_hi_const", {32'd0, E_HI}, 64'h0000_0002);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);           wait_done("div_neg7_2", -1, MD_NONE);
    check("div_lo_const", {32'd0, E_LO}, 64'hFFFF_FFFD);
    check("div_hi_const", {32'd0, E_HI}, 64'hFFFF_FFFF);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("div_ovf", -1, MD_NONE);
    check("div_ovf_lo_const", {32'd0, E_LO}, 64'h8000_0000);

    // mthi / mtlo and divide by zero
    move_to(MD_MTHI, 32'h1234_5678, "mthi");
    move_to(MD_MTLO, 32'hCAFE_F00D, "mtlo");
    issue(MD_DIVU, 32'd5, 32'd0);                  wait_done("divu_by0", -1, MD_NONE);
    check("divu0_hi_const", {32'd0, E_HI}, 64'h1234_5678);
    read_mf("after_div0");
    issue(MD_DIV, 32'h0000_0064, 32'd0);           wait_done("div_by0", -1, MD_NONE);

    // Overlap: illegal requests during busy are ignored
    issue(MD_MULT, 32'd7, 32'd9);                  wait_done("ovl_start", 2, MD_DIV);
    issue(MD_MULTU, 32'd11, 32'd13);               wait_done("ovl_mtlo", 3, MD_MTLO);
    issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0010);  wait_done("ovl_mfhi", 1, MD_MFHI);
    issue(MD_MULT, 32'd6, 32'd6);                  wait_done("start_last", MULT_CYCLES_DEF, MD_DIVU);
    issue(MD_DIVU, 32'd100, 32'd7);                wait_done("ovl_div_last", DIV_CYCLES_DEF, MD_MULT);
    @(negedge clk);
    check("start_last_idle", {63'd0, E_Busy}, 64'd0);

    // Randomized operations
    for (int i = 0; i < 8; i++) begin
      r_op = 4'($urandom_range(1, 4));
      r_a  = $urandom;
      r_b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50)));
      issue(r_op, r_a, r_b);
      wait_done($sformatf("rand%0d_op%0d", i, r_op), -1, MD_NONE);
    end

    // Reset in the middle of an operation
    issue(MD_MULT, 32'd3, 32'd5);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_busy_before", {63'd0, E_Busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, E_Busy}, 64'd0);
    check("mid_rst_hi", {32'd0, E_HI}, 64'd0);
    check("mid_rst_lo", {32'd0, E_LO}, 64'd0);
    sb_q.delete();
    arch_hi = 32'd0;
    arch_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {63'd0, E_Busy}, 64'd0);
    check("post_rst_hi", {32'd0, E_HI}, 64'd0);
    check("post_rst_lo", {32'd0, E_LO}, 64'd0);
    $display("mid_reset: HI=0x%08h LO=0x%08h busy=%0d", E_HI, E_LO, E_Busy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
